bmp_tx_sequencer: RTL and testbench
===================================

# bmp_tx_sequencer

Frame-transmit controller between the processed-image buffer and the UART transmitter. After a frame is fully written and a start request arrives, it streams a 54-byte BMP header, generated from the WIDTH and HEIGHT parameters, and then every pixel byte from the buffer's read port. It issues one byte per UART handshake and pulses a completion flag at the end.

## Interface
- WIDTH, 10: image width in pixels.
- HEIGHT, 5: image height in pixels.
- HDR_BYTES, 54: header length. Fixed at 54; no other value is supported.
- AW, 16: buffer read-address width. Must satisfy 2^AW >= WIDTH*HEIGHT*3.

- HCLK  in  1  clock.
- HRESET  in  1  reset, asynchronous, active-low.
- start  in  1  single-cycle request to send one frame.
- frame_ready  in  1  level; buffer holds a complete frame (driven by the writer's write_done).
- abort  in  1  synchronous cancel.
- rd_en  out  1  buffer read strobe, one cycle wide.
- rd_addr  out  AW  buffer byte address, 0..WIDTH*HEIGHT*3-1.
- rd_data  in  8  buffer byte. Valid in the cycle after rd_en; sampled at the second edge after rd_en is raised.
- TxD_start  out  1  UART byte-start pulse, one cycle wide.
- transmitData  out  8  byte to send. Held stable from TxD_start until the next byte is loaded.
- TxD_done  in  1  UART pulse: current byte has finished.
- busy  out  1  high from frame acceptance until return to IDLE.
- frame_sent  out  1  one-cycle pulse after the last byte's TxD_done.

## Operation
- States: IDLE, HDR_LOAD, PIX_RD, PIX_CAP, SEND, WAIT_DONE.
- Reset values: all outputs 0; state IDLE; hdr_idx 0; pix_addr 0.
- IDLE: if start && frame_ready, clear hdr_idx and pix_addr and go to HDR_LOAD. Otherwise, start is ignored.
- HDR_LOAD: transmitData <= header[hdr_idx]; go to SEND.
- PIX_RD: rd_en=1, rd_addr=pix_addr; go to PIX_CAP.
- PIX_CAP: transmitData <= rd_data; go to SEND.
- SEND: TxD_start=1 for exactly this cycle; go to WAIT_DONE.
- WAIT_DONE: hold until TxD_done, then:
  - Header byte, hdr_idx < 53: increment hdr_idx, go to HDR_LOAD.
  - Header byte, hdr_idx == 53: go to PIX_RD with pix_addr 0.
  - Pixel byte, pix_addr < WIDTH*HEIGHT*3-1: increment pix_addr, go to PIX_RD.
  - Last pixel byte: pulse frame_sent, go to IDLE.
- TxD_done is honoured only in WAIT_DONE; it is ignored in every other state.
- Header bytes, multi-byte fields little-endian. Let IMG = WIDTH*HEIGHT*3, with no row padding.
  - Bytes 0-1: 66, 77.
  - Bytes 2-5: 54 + IMG.
  - Bytes 6-9: 0.
  - Bytes 10-13: 54.
  - Bytes 14-17: 40.
  - Bytes 18-21: WIDTH.
  - Bytes 22-25: HEIGHT.
  - Bytes 26-27: 1.
  - Bytes 28-29: 24.
  - Bytes 30-33: 0.
  - Bytes 34-37: IMG.
  - Bytes 38-53: 0.
- Header arithmetic is 32-bit, from elaboration-time constants. There is no header ROM in RAM.
- Pixel bytes are sent in address order 0..IMG-1. The buffer already holds them in BMP order (bottom-up, B,G,R).
- abort has priority over every transition:
  - Next state is IDLE; busy=0.
  - TxD_start is forced low in the same cycle if SEND is active.
  - frame_sent is not pulsed; transmitData keeps its last value.
- Simultaneous abort and start in IDLE: abort wins and the frame is not accepted.
- frame_ready dropping mid-frame does not stop transmission; it is sampled only at acceptance.
- HRESET mid-frame returns all state and outputs to reset values immediately.

## Timing
- start sampled at edge N leads to:
  - busy=1 and state HDR_LOAD after N.
  - transmitData=66 after N+1.
  - TxD_start high in the cycle after N+1.
- Header inter-byte: TxD_done sampled at edge M gives TxD_start high after M+2.
- Pixel byte:
  - TxD_done at edge M gives rd_en high after M+1.
  - rd_data is captured at M+3.
  - TxD_start is high after M+3.
- The first pixel byte follows header byte 53's TxD_done with the same pixel timing.
- Last TxD_done at edge M gives frame_sent high after M+1, and busy=0 after M+1.
- All outputs are registered.

## Test plan
- Full frame, WIDTH=4, HEIGHT=2, buffer byte k = k, UART model returning TxD_done 5 cycles after TxD_start:
  - Expect 78 TxD_start pulses.
  - Bytes 0-53 match the header: bytes 2-5 = 78,0,0,0; bytes 18-21 = 4,0,0,0; bytes 34-37 = 24,0,0,0.
  - Pixel bytes are 0..23.
  - Exactly one frame_sent pulse.
- start with frame_ready=0 -> no state change, busy stays 0; a second start with frame_ready=1 is accepted.
- abort asserted in WAIT_DONE at pixel 10 -> IDLE the next cycle, no frame_sent. A following start resends from header byte 0.
- Stray TxD_done pulses in IDLE, and in the same cycle as SEND -> ignored; no byte skipped; byte count still 78.
- HRESET low during header byte 20 -> all outputs 0 immediately; after release, no activity until a new start.
- start re-pulsed while busy -> ignored; exactly one frame is sent.

Source files
------------

// File: rtl/bmp_tx_sequencer.sv
// bmp_tx_sequencer
// Streams one BMP frame to a byte-wide UART transmitter. The frame is a
// 54-byte header built from WIDTH/HEIGHT at elaboration time, followed by
// the WIDTH*HEIGHT*3 pixel bytes read in address order from the buffer.
// One byte is sent per TxD_start/TxD_done handshake.
//
// Ports
//   HCLK, HRESET      clock, asynchronous active-low reset
//   start             single-cycle frame request (accepted only with frame_ready)
//   frame_ready       buffer holds a complete frame (sampled at acceptance only)
//   abort             synchronous cancel, returns to IDLE
//   rd_en, rd_addr    buffer read strobe and byte address
//   rd_data           buffer byte, valid the cycle after rd_en
//   TxD_start         one-cycle UART byte-start pulse
//   transmitData      byte presented to the UART, held until the next load
//   TxD_done          UART byte-finished pulse
//   busy              frame in progress
//   frame_sent        one-cycle pulse after the last byte completes
module bmp_tx_sequencer #(
  parameter int WIDTH     = 10,
  parameter int HEIGHT    = 5,
  parameter int HDR_BYTES = 54,
  parameter int AW        = 16
) (
  input  logic          HCLK,
  input  logic          HRESET,
  input  logic          start,
  input  logic          frame_ready,
  input  logic          abort,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [7:0]    rd_data,
  output logic          TxD_start,
  output logic [7:0]    transmitData,
  input  logic          TxD_done,
  output logic          busy,
  output logic          frame_sent
);

  localparam logic [31:0]   IMG      = 32'(WIDTH * HEIGHT * 3);
  localparam logic [31:0]   HDR32    = 32'(HDR_BYTES);
  localparam logic [31:0]   FSIZE    = HDR32 + IMG;
  localparam logic [5:0]    HDR_LAST = 6'(HDR_BYTES - 1);
  localparam logic [AW-1:0] PIX_LAST = AW'(WIDTH * HEIGHT * 3 - 1);

  typedef enum logic [2:0] {IDLE, HDR_LOAD, PIX_RD, PIX_CAP, SEND, WAIT_DONE} state_t;

  // Byte k (0..3) of a little-endian 32-bit field.
  function automatic logic [7:0] le_byte(input logic [31:0] v, input logic [5:0] k);
    return 8'(v >> {k, 3'b000});
  endfunction

  function automatic logic [7:0] hdr_byte(input logic [5:0] idx);
    logic [7:0] b;
    b = 8'd0;
    if (idx == 6'd0)                      b = 8'd66;
    else if (idx == 6'd1)                 b = 8'd77;
    else if (idx >= 6'd2  && idx <= 6'd5)  b = le_byte(FSIZE, idx - 6'd2);
    else if (idx >= 6'd10 && idx <= 6'd13) b = le_byte(HDR32, idx - 6'd10);
    else if (idx >= 6'd14 && idx <= 6'd17) b = le_byte(32'd40, idx - 6'd14);
    else if (idx >= 6'd18 && idx <= 6'd21) b = le_byte(32'(WIDTH), idx - 6'd18);
    else if (idx >= 6'd22 && idx <= 6'd25) b = le_byte(32'(HEIGHT), idx - 6'd22);
    else if (idx >= 6'd26 && idx <= 6'd27) b = le_byte(32'd1, idx - 6'd26);
    else if (idx >= 6'd28 && idx <= 6'd29) b = le_byte(32'd24, idx - 6'd28);
    else if (idx >= 6'd34 && idx <= 6'd37) b = le_byte(IMG, idx - 6'd34);
    return b;
  endfunction

  state_t        state_q, state_d;
  logic [5:0]    hdr_idx_q, hdr_idx_d;
  logic [AW-1:0] pix_addr_q, pix_addr_d;
  logic          pix_phase_q, pix_phase_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;
  logic          txs_q, txs_d;
  logic          rd_en_q, rd_en_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          fsent_q, fsent_d;

  // TxD_done is registered once and only while waiting for it, so a pulse
  // landing in any other state (including SEND) can never count as done.
  assign done_d = TxD_done && (state_q == WAIT_DONE);

  always_comb begin
    state_d     = state_q;
    hdr_idx_d   = hdr_idx_q;
    pix_addr_d  = pix_addr_q;
    pix_phase_d = pix_phase_q;
    busy_d      = busy_q;
    txs_d       = 1'b0;
    rd_en_d     = 1'b0;
    rd_addr_d   = rd_addr_q;
    tx_data_d   = tx_data_q;
    fsent_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start && frame_ready) begin
          hdr_idx_d   = 6'd0;
          pix_addr_d  = '0;
          pix_phase_d = 1'b0;
          busy_d      = 1'b1;
          state_d     = HDR_LOAD;
        end
      end
      HDR_LOAD: begin
        tx_data_d = hdr_byte(hdr_idx_q);
        txs_d     = 1'b1;
        state_d   = SEND;
      end
      // rd_en was raised on entry; the buffer answers during PIX_CAP.
      PIX_RD: state_d = PIX_CAP;
      PIX_CAP: begin
        tx_data_d = rd_data;
        txs_d     = 1'b1;
        state_d   = SEND;
      end
      SEND: state_d = WAIT_DONE;
      WAIT_DONE: begin
        if (done_q) begin
          if (!pix_phase_q) begin
            if (hdr_idx_q != HDR_LAST) begin
              hdr_idx_d = hdr_idx_q + 6'd1;
              state_d   = HDR_LOAD;
            end else begin
              pix_phase_d = 1'b1;
              pix_addr_d  = '0;
              rd_en_d     = 1'b1;
              rd_addr_d   = '0;
              state_d     = PIX_RD;
            end
          end else if (pix_addr_q != PIX_LAST) begin
            pix_addr_d = pix_addr_q + 1'b1;
            rd_en_d    = 1'b1;
            rd_addr_d  = pix_addr_q + 1'b1;
            state_d    = PIX_RD;
          end else begin
            fsent_d = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // abort overrides every transition; the data byte is left as it was.
    if (abort) begin
      state_d   = IDLE;
      busy_d    = 1'b0;
      txs_d     = 1'b0;
      rd_en_d   = 1'b0;
      fsent_d   = 1'b0;
      tx_data_d = tx_data_q;
    end
  end

  always_ff @(posedge HCLK or negedge HRESET) begin
    if (!HRESET) begin
      state_q     <= IDLE;
      hdr_idx_q   <= 6'd0;
      pix_addr_q  <= '0;
      pix_phase_q <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      txs_q       <= 1'b0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      tx_data_q   <= 8'd0;
      fsent_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      hdr_idx_q   <= hdr_idx_d;
      pix_addr_q  <= pix_addr_d;
      pix_phase_q <= pix_phase_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      txs_q       <= txs_d;
      rd_en_q     <= rd_en_d;
      rd_addr_q   <= rd_addr_d;
      tx_data_q   <= tx_data_d;
      fsent_q     <= fsent_d;
    end
  end

  assign rd_en        = rd_en_q;
  assign rd_addr      = rd_addr_q;
  assign TxD_start    = txs_q;
  assign transmitData = tx_data_q;
  assign busy         = busy_q;
  assign frame_sent   = fsent_q;

endmodule

// File: tb/tb_bmp_tx_sequencer.sv
module tb_bmp_tx_sequencer;
  localparam int W      = 4;
  localparam int H      = 2;
  localparam int AW     = 16;
  localparam int NBYTES = 78;

  logic          HCLK = 1'b0;
  logic          HRESET = 1'b0;
  logic          start = 1'b0;
  logic          frame_ready = 1'b0;
  logic          abort = 1'b0;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data = 8'hA5;
  logic          TxD_start;
  logic [7:0]    transmitData;
  logic          TxD_done;
  logic          busy;
  logic          frame_sent;

  logic tb_done = 1'b0;
  logic uart_done = 1'b0;
  logic uart_stray = 1'b0;
  bit   uart_on = 1'b0;
  bit   stray_mode = 1'b0;
  assign TxD_done = tb_done | uart_done | uart_stray;

  int checks = 0;
  int errors = 0;
  byte unsigned sent_q[$];
  int fs_cnt = 0;
  int ucnt = 0;
  int neg_cnt = 0;
  int last_done_t = -1;
  logic [7:0] exp_bytes [NBYTES];

  always #5 HCLK = ~HCLK;

  bmp_tx_sequencer #(.WIDTH(W), .HEIGHT(H), .HDR_BYTES(54), .AW(AW)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .start(start), .frame_ready(frame_ready),
    .abort(abort), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .TxD_start(TxD_start), .transmitData(transmitData), .TxD_done(TxD_done),
    .busy(busy), .frame_sent(frame_sent)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  // Buffer: byte k holds k; outside the valid cycle the data is junk.
  always @(posedge HCLK) rd_data <= rd_en ? rd_addr[7:0] : 8'hA5;

  // UART model + byte/latency monitor, evaluated on the falling edge.
  always @(negedge HCLK) begin
    neg_cnt++;
    if (!HRESET) begin
      ucnt = 0; uart_done = 1'b0; uart_stray = 1'b0; last_done_t = -1;
    end else begin
      uart_stray = stray_mode && TxD_start;
      uart_done  = 1'b0;
      if (TxD_start) begin
        if (last_done_t >= 0)
          chk("txstart_latency", neg_cnt - last_done_t, (sent_q.size() >= 54) ? 4 : 3);
        sent_q.push_back(transmitData);
        ucnt = 5;
      end else if (ucnt != 0) begin
        ucnt--;
        if (ucnt == 0 && uart_on) begin
          uart_done = 1'b1;
          last_done_t = neg_cnt;
        end
      end
      if (rd_en) begin
        chk("rd_en_latency", neg_cnt - last_done_t, 2);
        chk("rd_addr", int'(rd_addr), sent_q.size() - 54);
      end
      if (frame_sent) fs_cnt++;
      if (!busy) last_done_t = -1;
    end
  end

  task automatic step();
    @(negedge HCLK);
    #1;
  endtask

  task automatic put32(input int off, input int v);
    for (int k = 0; k < 4; k++) exp_bytes[off + k] = 8'(v >> (8 * k));
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_txstart"}, TxD_start, 0);
    chk({tag, "_txdata"}, transmitData, 0);
    chk({tag, "_rd_en"}, rd_en, 0);
    chk({tag, "_rd_addr"}, int'(rd_addr), 0);
    chk({tag, "_frame_sent"}, frame_sent, 0);
  endtask

  task automatic pulse_start();
    start = 1'b1; frame_ready = 1'b1;
    step();
    start = 1'b0; frame_ready = 1'b0;
  endtask

  task automatic run_frame(input bit stray, input bit repulse);
    bit got;
    step();
    sent_q.delete();
    fs_cnt = 0; uart_on = 1'b1; stray_mode = stray;
    if (stray) begin
      for (int k = 0; k < 2; k++) begin
        tb_done = 1'b1; step(); tb_done = 1'b0; step();
      end
      chk("stray_idle_busy", busy, 0);
    end
    pulse_start();
    chk("accept_busy", busy, 1);
    got = 1'b0;
    for (int cyc = 0; cyc < 3000 && !got; cyc++) begin
      start = repulse && (cyc == 150);
      frame_ready = start;
      step();
      if (frame_sent) begin
        got = 1'b1;
        chk("busy_at_frame_sent", busy, 0);
      end
    end
    start = 1'b0; frame_ready = 1'b0;
    chk("frame_within_budget", got, 1);
    repeat (30) step();
    chk("frame_sent_count", fs_cnt, 1);
    chk("busy_after_frame", busy, 0);
    chk("byte_count", sent_q.size(), NBYTES);
    for (int i = 0; i < NBYTES && i < sent_q.size(); i++)
      chk($sformatf("byte[%0d]", i), sent_q[i], exp_bytes[i]);
    stray_mode = 1'b0;
  endtask

  typedef struct {
    logic       st, fr, ab, dn;
    logic       e_busy, e_ts;
    logic [7:0] e_td;
  } vec_t;
  vec_t tbl[12];

  initial begin
    // Expected frame for WIDTH=4, HEIGHT=2: 24 pixel bytes, file size 78.
    for (int i = 0; i < NBYTES; i++) exp_bytes[i] = 8'd0;
    exp_bytes[0] = 8'd66; exp_bytes[1] = 8'd77;
    put32(2, 78); put32(10, 54); put32(14, 40); put32(18, 4); put32(22, 2);
    exp_bytes[26] = 8'd1; exp_bytes[28] = 8'd24; put32(34, 24);
    for (int k = 0; k < 24; k++) exp_bytes[54 + k] = 8'(k);

    //             st    fr    ab    dn    busy  ts    td
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};   // no frame_ready
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[2]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};   // abort beats start
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0};   // accepted -> HDR_LOAD
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd66};  // SEND byte 0
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd66};  // done during SEND ignored
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd66};  // start while busy ignored
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd66};  // real done
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd66};  // HDR_LOAD
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd77};  // SEND byte 1
    tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd77};  // abort, data kept
    tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd77};  // stray done in IDLE

    step();
    check_outputs_zero("reset");
    step();
    HRESET = 1'b1;
    step();
    check_outputs_zero("post_reset");

    for (int i = 0; i < 12; i++) begin
      start = tbl[i].st; frame_ready = tbl[i].fr; abort = tbl[i].ab; tb_done = tbl[i].dn;
      step();
      chk($sformatf("vec%0d_busy", i), busy, tbl[i].e_busy);
      chk($sformatf("vec%0d_txstart", i), TxD_start, tbl[i].e_ts);
      chk($sformatf("vec%0d_txdata", i), transmitData, tbl[i].e_td);
      chk($sformatf("vec%0d_rd_en", i), rd_en, 0);
      chk($sformatf("vec%0d_frame_sent", i), frame_sent, 0);
    end
    start = 1'b0; frame_ready = 1'b0; abort = 1'b0; tb_done = 1'b0;
    repeat (10) step();

    // Full frame, then one with stray done pulses and a start re-pulse.
    run_frame(1'b0, 1'b0);
    run_frame(1'b1, 1'b1);

    // Abort while waiting on pixel byte 10.
    begin
      bit hit;
      sent_q.delete(); fs_cnt = 0; uart_on = 1'b1;
      pulse_start();
      hit = 1'b0;
      for (int cyc = 0; cyc < 3000 && !hit; cyc++) begin
        step();
        if (sent_q.size() == 65) hit = 1'b1;
      end
      chk("abort_reach_pixel10", hit, 1);
      step();
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("abort_busy", busy, 0);
      chk("abort_txstart", TxD_start, 0);
      chk("abort_txdata_kept", transmitData, 10);
      repeat (20) step();
      chk("abort_no_frame_sent", fs_cnt, 0);
      chk("abort_no_more_bytes", sent_q.size(), 65);
      chk("abort_idle_rd_en", rd_en, 0);
    end
    run_frame(1'b0, 1'b0);

    // Reset during header byte 20.
    begin
      bit hit;
      sent_q.delete(); fs_cnt = 0;
      pulse_start();
      hit = 1'b0;
      for (int cyc = 0; cyc < 3000 && !hit; cyc++) begin
        step();
        if (sent_q.size() == 21) hit = 1'b1;
      end
      chk("reset_reach_hdr20", hit, 1);
      step();
      HRESET = 1'b0;
      #1;
      check_outputs_zero("midframe_reset");
      step(); step();
      HRESET = 1'b1;
      repeat (20) step();
      chk("after_reset_busy", busy, 0);
      chk("after_reset_no_bytes", sent_q.size(), 21);
      chk("after_reset_no_frame_sent", fs_cnt, 0);
    end
    run_frame(1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
